// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: sequencer state
// encoding, the zero word used for clearing/masking, and an address range
// helper.
package reg_file_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    // Widest supported data word is 64 bits; narrower words take the low slice.
    localparam logic [63:0] ZERO_WORD = 64'd0;

    // True when an address names an implemented register.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned nregs);
        return (addr < nregs);
    endfunction

endpackage

// File: rtl/reg_file_mem.sv
// Register storage: NREGS x XLEN words, one synchronous write port and one
// asynchronous read port. No reset; the owner runs a clear sequence instead.
module reg_file_mem #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Write port: caller guarantees waddr_i is in range whenever we_i is high.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-operand register file. A phase sequencer reads one operand per cycle
// through a single array read port, forwards concurrent writes into pending
// results, and presents all operands together with a one-cycle rsp_valid.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic                rsp_valid,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                we,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     rd_v
);

    localparam int PW = (NRD > 1) ? $clog2(NRD) : 1;

    state_e                state_q, state_d;
    logic [AW-1:0]         clr_idx_q, clr_idx_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [NRD*AW-1:0]     addr_q, addr_d;
    logic [NRD*XLEN-1:0]   cap_q, cap_d;
    logic [NRD*XLEN-1:0]   rs_data_q, rs_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  req_ready_q, req_ready_d;

    logic                  clr_done_s;
    logic                  last_phase_s;
    logic                  wr_accept_s;
    logic [NRD-1:0]        fwd_s;
    logic                  mem_we_s;
    logic [AW-1:0]         mem_waddr_s;
    logic [XLEN-1:0]       mem_wdata_s;
    logic [AW-1:0]         mem_raddr_s;
    logic [XLEN-1:0]       mem_rdata_s;
    logic [XLEN-1:0]       rd_value_s;

    assign clr_done_s   = (clr_idx_q == AW'(NREGS - 1));
    assign last_phase_s = (phase_q == PW'(NRD - 1));
    assign mem_raddr_s  = addr_q[32'(phase_q) * AW +: AW];

    // A user write lands only outside CLEAR, in range, and not on a hardwired zero.
    always_comb begin
        wr_accept_s = 1'b0;
        if (we && (state_q != ST_CLEAR) && addr_ok(32'(rd), NREGS)
            && !((ZERO_REG != 0) && (rd == '0))) begin
            wr_accept_s = 1'b1;
        end else begin
            wr_accept_s = 1'b0;
        end
    end

    // Per-port forwarding hit: an accepted write to that port's latched address.
    always_comb begin
        fwd_s = '0;
        for (int k = 0; k < NRD; k++) begin
            fwd_s[k] = (BYPASS != 0) && wr_accept_s && (rd == addr_q[k*AW +: AW]);
        end
    end

    // Array write mux: the clear sequence owns the write port during CLEAR.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = XLEN'(ZERO_WORD);
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_q;
            mem_wdata_s = XLEN'(ZERO_WORD);
        end else begin
            mem_we_s    = wr_accept_s;
            mem_waddr_s = rd;
            mem_wdata_s = rd_v;
        end
    end

    // Read masking: register 0 (when hardwired) and unimplemented addresses read zero.
    always_comb begin
        rd_value_s = XLEN'(ZERO_WORD);
        if (!addr_ok(32'(mem_raddr_s), NREGS)
            || ((ZERO_REG != 0) && (mem_raddr_s == '0))) begin
            rd_value_s = XLEN'(ZERO_WORD);
        end else begin
            rd_value_s = mem_rdata_s;
        end
    end

    reg_file_mem #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we_s),
        .waddr_i (mem_waddr_s),
        .wdata_i (mem_wdata_s),
        .raddr_i (mem_raddr_s),
        .rdata_o (mem_rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_done_s) state_d = ST_IDLE;
                else            state_d = ST_CLEAR;
            end
            ST_IDLE: begin
                if (req_valid) state_d = ST_READ;
                else           state_d = ST_IDLE;
            end
            ST_READ: begin
                if (last_phase_s) state_d = ST_IDLE;
                else              state_d = ST_READ;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // FSM outputs: ready is registered so it tracks the IDLE state exactly.
    always_comb begin
        req_ready_d = 1'b0;
        case (state_d)
            ST_IDLE: req_ready_d = 1'b1;
            default: req_ready_d = 1'b0;
        endcase
    end

    // Datapath next state: clear counter, phase sequencing, capture and forwarding.
    always_comb begin
        clr_idx_d   = clr_idx_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        cap_d       = cap_q;
        rs_data_d   = rs_data_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_done_s) clr_idx_d = '0;
                else            clr_idx_d = clr_idx_q + AW'(1);
            end
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = rs_addr;
                    phase_d = '0;
                end else begin
                    addr_d  = addr_q;
                end
            end
            ST_READ: begin
                for (int k = 0; k < NRD; k++) begin
                    if (k == int'(phase_q)) begin
                        if (fwd_s[k]) cap_d[k*XLEN +: XLEN] = rd_v;
                        else          cap_d[k*XLEN +: XLEN] = rd_value_s;
                    end else if ((k < int'(phase_q)) && fwd_s[k]) begin
                        cap_d[k*XLEN +: XLEN] = rd_v;
                    end else begin
                        cap_d[k*XLEN +: XLEN] = cap_q[k*XLEN +: XLEN];
                    end
                end
                if (last_phase_s) begin
                    // Results include any write accepted at this very edge.
                    rs_data_d   = cap_d;
                    rsp_valid_d = 1'b1;
                    phase_d     = '0;
                end else begin
                    phase_d     = phase_q + PW'(1);
                end
            end
            default: clr_idx_d = '0;
        endcase
    end

    // Datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx_q   <= '0;
            phase_q     <= '0;
            addr_q      <= '0;
            cap_q       <= '0;
            rs_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            clr_idx_q   <= clr_idx_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            cap_q       <= cap_d;
            rs_data_q   <= rs_data_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rs_data   = rs_data_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build (A), ZERO_REG=0/BYPASS=0
// build (B) sharing A's stimulus, and an NRD=3/XLEN=16/NREGS=16 build (C).
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid;
    logic [9:0]  rs_addr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_v;
    logic        req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
    logic [63:0] rs_data_a, rs_data_b;

    logic        req_valid_c;
    logic [11:0] rs_addr_c;
    logic        we_c;
    logic [3:0]  rd_c;
    logic [15:0] rd_v_c;
    logic        req_ready_c, rsp_valid_c;
    logic [47:0] rs_data_c;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
        .rs_addr(rs_addr), .rsp_valid(rsp_valid_a), .rs_data(rs_data_a),
        .we(we), .rd(rd), .rd_v(rd_v));

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
        .rs_addr(rs_addr), .rsp_valid(rsp_valid_b), .rs_data(rs_data_b),
        .we(we), .rd(rd), .rd_v(rd_v));

    reg_file_mp #(.XLEN(16), .NREGS(16), .NRD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .rs_addr(rs_addr_c), .rsp_valid(rsp_valid_c), .rs_data(rs_data_c),
        .we(we_c), .rd(rd_c), .rd_v(rd_v_c));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        do_wr;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock, then sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ab(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; rd = a; rd_v = d;
        step();
        we = 1'b0;
    endtask

    task automatic wait_ready_ab();
        int guard = 0;
        while (!req_ready_a && guard < 100) begin
            step();
            guard++;
        end
        check("req_ready_before_req", 64'(req_ready_a), 64'd1);
    endtask

    task automatic req_ab(input string name, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] ea0, input logic [31:0] ea1,
                          input logic [31:0] eb0, input logic [31:0] eb1);
        int lat = -1;
        wait_ready_ab();
        req_valid = 1'b1;
        rs_addr   = {a1, a0};
        step();                       // accept edge E0
        req_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (rsp_valid_a) begin
                lat = n;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        check({name, "_rsp_valid_b"}, 64'(rsp_valid_b), 64'd1);
        check({name, "_data_a"}, rs_data_a, {ea1, ea0});
        check({name, "_data_b"}, rs_data_b, {eb1, eb0});
        step();
        check({name, "_pulse_end"}, 64'(rsp_valid_a), 64'd0);
        check({name, "_hold_a"}, rs_data_a, {ea1, ea0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_a_at;
        int rdy_c_at;
        int p1;
        int p2;
        int npulse;

        vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd4, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd4,  32'h12345678, 5'd3,  5'd4, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd3, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};

        req_valid = 1'b0; rs_addr = 10'd0; we = 1'b0; rd = 5'd0; rd_v = 32'd0;
        req_valid_c = 1'b0; rs_addr_c = 12'd0; we_c = 1'b0; rd_c = 4'd0; rd_v_c = 16'd0;
        rst = 1'b1;

        // Reset state, then clear-sequence duration.
        step();
        step();
        check("rst_req_ready_a", 64'(req_ready_a), 64'd0);
        check("rst_rsp_valid_a", 64'(rsp_valid_a), 64'd0);
        check("rst_rs_data_a", rs_data_a, 64'd0);
        check("rst_req_ready_c", 64'(req_ready_c), 64'd0);
        rst = 1'b0;
        rdy_a_at = -1;
        rdy_c_at = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (req_ready_a && rdy_a_at < 0) rdy_a_at = n;
            if (req_ready_c && rdy_c_at < 0) rdy_c_at = n;
        end
        check("clear_len_a", 64'(rdy_a_at), 64'd32);
        check("clear_len_c", 64'(rdy_c_at), 64'd16);

        // Table-driven write/read vectors.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_wr) write_ab(vecs[i].wr_addr, vecs[i].wr_data);
            req_ab($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1,
                   vecs[i].ea0, vecs[i].ea1, vecs[i].eb0, vecs[i].eb1);
        end

        // Forwarding: write accepted at the edge ending phase 1.
        write_ab(5'd9, 32'h1);
        wait_ready_ab();
        req_valid = 1'b1; rs_addr = {5'd9, 5'd9};
        step();                       // E0
        req_valid = 1'b0;
        step();                       // E0+1, now in phase 1
        we = 1'b1; rd = 5'd9; rd_v = 32'h2;
        step();                       // E0+2
        we = 1'b0;
        check("fwd_p1_rsp_valid_a", 64'(rsp_valid_a), 64'd1);
        check("fwd_p1_data_a", rs_data_a, {32'h2, 32'h2});
        check("fwd_p1_data_b", rs_data_b, {32'h1, 32'h1});

        // Forwarding: write accepted at the edge ending phase 0.
        wait_ready_ab();
        req_valid = 1'b1; rs_addr = {5'd9, 5'd9};
        step();                       // E0, now in phase 0
        req_valid = 1'b0;
        we = 1'b1; rd = 5'd9; rd_v = 32'h3;
        step();                       // E0+1
        we = 1'b0;
        step();                       // E0+2
        check("fwd_p0_rsp_valid_a", 64'(rsp_valid_a), 64'd1);
        check("fwd_p0_data_a", rs_data_a, {32'h3, 32'h3});
        check("fwd_p0_data_b", rs_data_b, {32'h3, 32'h2});

        // Three-port build: back-to-back requests.
        for (int i = 1; i <= 3; i++) begin
            we_c = 1'b1; rd_c = 4'(i); rd_v_c = 16'(i * 16'h11);
            step();
        end
        we_c = 1'b0;
        check("c_ready_before_req", 64'(req_ready_c), 64'd1);
        req_valid_c = 1'b1; rs_addr_c = {4'd3, 4'd2, 4'd1};
        step();                       // E0
        rs_addr_c = {4'd1, 4'd2, 4'd3};
        p1 = -1; p2 = -1; npulse = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 4) req_valid_c = 1'b0;
            if (rsp_valid_c) begin
                npulse++;
                if (p1 < 0) begin
                    p1 = n;
                    check("c_rsp1_data", 64'(rs_data_c), 64'({16'h33, 16'h22, 16'h11}));
                end else begin
                    p2 = n;
                    check("c_rsp2_data", 64'(rs_data_c), 64'({16'h11, 16'h22, 16'h33}));
                end
            end
        end
        check("c_rsp1_cycle", 64'(p1), 64'd3);
        check("c_rsp2_cycle", 64'(p2), 64'd7);
        check("c_pulse_count", 64'(npulse), 64'd2);
        check("c_hold", 64'(rs_data_c), 64'({16'h11, 16'h22, 16'h33}));

        // Reset in phase 0 of a request: no response, storage cleared.
        wait_ready_ab();
        req_valid = 1'b1; rs_addr = {5'd4, 5'd3};
        step();                       // E0
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_rsp_valid_a", 64'(rsp_valid_a), 64'd0);
        check("midrst_rs_data_a", rs_data_a, 64'd0);
        check("midrst_req_ready_a", 64'(req_ready_a), 64'd0);
        rst = 1'b0;
        npulse = 0;
        rdy_a_at = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (rsp_valid_a) npulse++;
            if (req_ready_a && rdy_a_at < 0) rdy_a_at = n;
        end
        check("midrst_no_rsp", 64'(npulse), 64'd0);
        check("midrst_clear_len", 64'(rdy_a_at), 64'd32);
        req_ab("after_clear", 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
